// File: rtl/line_centroid_extract.sv
// line_centroid_extract
//
// Pixel-domain stage feeding the line-follow display/error block. Each
// RGB565 pixel is classified as yellow or not; over the row band
// ROI_Y0..ROI_Y1 the block accumulates the yellow pixel count and the sum of
// their x coordinates. At every frame end (vsync rising edge) those totals
// are handed to a 32-cycle restoring divider. The divider runs while the next
// frame accumulates. The results are published with a one-cycle frame_pulse.
//
// Optional build macro: LINE_CENTROID_IIR_EN
//   When defined, centroid_x is smoothed across detected frames:
//   c <= (3*c + q) >> 2. The first detected frame after reset loads q directly.
//   A non-detected frame holds c. When undefined, centroid_x is the raw
//   quotient on detected frames and 0 otherwise.
//
// Ports:
//   clk          pixel clock, the only clock
//   reset        synchronous, active-high reset
//   vsync        frame sync; a rising edge marks a frame boundary
//   href         line valid
//   pix_valid    pix_data carries a pixel (only while href is high)
//   pix_data     RGB565 pixel: R[15:11], G[10:5], B[4:0]
//   frame_pulse  one-cycle strobe; width/centroid_x/detected update with it
//   width        pixel count of the last completed line of the frame
//   centroid_x   floor(sum_x / count), or the smoothed value
//   detected     yellow ROI pixel count >= MIN_COUNT
//   busy         divider running (run and done states)
//   overrun      sticky; a frame end arrived while the divider was busy
//
// Pixel qualification: there is no back-pressure. A pixel is consumed in
// every cycle where href && pix_valid. A frame end is taken in the cycle
// vsync rises, whether or not the divider can accept it.

module line_centroid_extract #(
    parameter int THR_R     = 20,
    parameter int THR_G     = 40,
    parameter int THR_B     = 12,
    parameter int ROI_Y0    = 240,
    parameter int ROI_Y1    = 479,
    parameter int MIN_COUNT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        href,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        frame_pulse,
    output logic [15:0] width,
    output logic [15:0] centroid_x,
    output logic        detected,
    output logic        busy,
    output logic        overrun
);

    localparam logic [4:0]  THR_R5  = THR_R[4:0];
    localparam logic [5:0]  THR_G6  = THR_G[5:0];
    localparam logic [4:0]  THR_B5  = THR_B[4:0];
    localparam logic [15:0] ROI_LO  = ROI_Y0[15:0];
    localparam logic [15:0] ROI_HI  = ROI_Y1[15:0];
    localparam logic [19:0] MIN_CNT = MIN_COUNT[19:0];

    typedef enum logic {
        F_IDLE,
        F_ACTIVE
    } frame_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_RUN,
        D_DONE
    } div_state_t;

    frame_state_t frame_state;
    div_state_t   div_state;

    // Edge detection
    logic vsync_d;
    logic href_d;
    logic vs_rise;
    logic href_fall;
    logic pix_take;
    logic is_yellow;
    logic frame_end;

    assign vs_rise   = vsync & ~vsync_d;
    assign href_fall = href_d & ~href;
    assign pix_take  = href & pix_valid;
    assign is_yellow = (pix_data[15:11] >= THR_R5) &&
                       (pix_data[10:5]  >= THR_G6) &&
                       (pix_data[4:0]   <= THR_B5);
    assign frame_end = (frame_state == F_ACTIVE) && vs_rise;

    // Frame accumulators
    logic [15:0] x_cnt;
    logic [15:0] y_cnt;
    logic [15:0] line_w;
    logic [19:0] count_acc;
    logic [31:0] sum_acc;

    logic [15:0] x_base, y_base, lw_base;
    logic [19:0] cnt_base;
    logic [31:0] sum_base;
    logic [15:0] x_nxt, y_nxt, lw_nxt;
    logic [19:0] cnt_nxt;
    logic [31:0] sum_nxt;
    logic [15:0] lw_end;
    logic        in_roi;

    // On a frame end the old frame's totals go to the divider and the
    // accumulators restart from zero in the same cycle. A pixel arriving in
    // that cycle is therefore counted against the new frame at x=0, y=0.
    always_comb begin
        cnt_base = vs_rise ? 20'd0 : count_acc;
        sum_base = vs_rise ? 32'd0 : sum_acc;
        x_base   = vs_rise ? 16'd0 : x_cnt;
        y_base   = vs_rise ? 16'd0 : y_cnt;
        lw_base  = vs_rise ? 16'd0 : line_w;
        in_roi   = (y_base >= ROI_LO) && (y_base <= ROI_HI);

        cnt_nxt  = cnt_base;
        sum_nxt  = sum_base;
        x_nxt    = x_base;
        y_nxt    = y_base;
        lw_nxt   = lw_base;

        if (pix_take) begin
            if (x_base != 16'hFFFF) begin
                x_nxt = x_base + 16'd1;
            end
            if (is_yellow && in_roi) begin
                if (cnt_base != 20'hFFFFF) begin
                    cnt_nxt = cnt_base + 20'd1;
                end
                sum_nxt = sum_base + {16'd0, x_base};
            end
        end

        // A line ending together with the frame end belongs to the old frame.
        // It is captured through lw_end below and does not touch the new frame.
        if (href_fall && !vs_rise) begin
            lw_nxt = x_cnt;
            x_nxt  = 16'd0;
            if (y_cnt != 16'hFFFF) begin
                y_nxt = y_cnt + 16'd1;
            end
        end

        lw_end = href_fall ? x_cnt : line_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_state <= F_IDLE;
            x_cnt       <= 16'd0;
            y_cnt       <= 16'd0;
            line_w      <= 16'd0;
            count_acc   <= 20'd0;
            sum_acc     <= 32'd0;
        end else begin
            case (frame_state)
                F_IDLE: begin
                    // No frame is in progress, so the first edge only opens one.
                    if (vs_rise) begin
                        x_cnt       <= 16'd0;
                        y_cnt       <= 16'd0;
                        line_w      <= 16'd0;
                        count_acc   <= 20'd0;
                        sum_acc     <= 32'd0;
                        frame_state <= F_ACTIVE;
                    end
                end
                F_ACTIVE: begin
                    x_cnt     <= x_nxt;
                    y_cnt     <= y_nxt;
                    line_w    <= lw_nxt;
                    count_acc <= cnt_nxt;
                    sum_acc   <= sum_nxt;
                end
                default: frame_state <= F_IDLE;
            endcase
        end
    end

    // Divider: restoring division, one quotient bit per cycle, MSB first
    logic [31:0] div_rem;
    logic [31:0] div_q;
    logic [31:0] div_den;
    logic [4:0]  bit_cnt;
    logic [15:0] snap_w;

    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        take;
    logic [31:0] rem_step;
    logic [31:0] q_step;
    logic [15:0] quot16;
    logic        hit_min;

    // The remainder is always below the divisor (at most 20 bits), so the
    // shifted remainder fits comfortably in 33 bits.
    always_comb begin
        rem_sh   = {div_rem, div_q[31]};
        rem_diff = rem_sh - {1'b0, div_den};
        take     = ~rem_diff[32];
        rem_step = take ? rem_diff[31:0] : rem_sh[31:0];
        q_step   = {div_q[30:0], take};
        // A zero divisor yields all ones, so the quotient is forced to 0.
        quot16   = (div_den == 32'd0) ? 16'd0 : q_step[15:0];
        hit_min  = (div_den[19:0] >= MIN_CNT);
    end

`ifdef LINE_CENTROID_IIR_EN
    logic        iir_valid;
    logic [17:0] iir_acc;

    // 3*c + q, kept at 18 bits so that it cannot overflow
    assign iir_acc = {2'b00, centroid_x} + {1'b0, centroid_x, 1'b0} + {2'b00, quot16};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state   <= D_IDLE;
            div_rem     <= 32'd0;
            div_q       <= 32'd0;
            div_den     <= 32'd0;
            bit_cnt     <= 5'd0;
            snap_w      <= 16'd0;
            frame_pulse <= 1'b0;
            width       <= 16'd0;
            centroid_x  <= 16'd0;
            detected    <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
`ifdef LINE_CENTROID_IIR_EN
            iir_valid   <= 1'b0;
`endif
        end else begin
            // A frame end while the divider is occupied loses that frame.
            if (frame_end && (div_state != D_IDLE)) begin
                overrun <= 1'b1;
            end

            case (div_state)
                D_IDLE: begin
                    frame_pulse <= 1'b0;
                    if (frame_end) begin
                        div_rem   <= 32'd0;
                        div_q     <= sum_acc;
                        div_den   <= {12'd0, count_acc};
                        snap_w    <= lw_end;
                        bit_cnt   <= 5'd0;
                        busy      <= 1'b1;
                        div_state <= D_RUN;
                    end
                end
                D_RUN: begin
                    div_rem <= rem_step;
                    div_q   <= q_step;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        // The final quotient bit is resolved in this cycle,
                        // so publish directly from the step logic.
                        frame_pulse <= 1'b1;
                        width       <= snap_w;
                        detected    <= hit_min;
`ifdef LINE_CENTROID_IIR_EN
                        if (hit_min) begin
                            iir_valid  <= 1'b1;
                            centroid_x <= iir_valid ? iir_acc[17:2] : quot16;
                        end
`else
                        centroid_x  <= hit_min ? quot16 : 16'd0;
`endif
                        div_state   <= D_DONE;
                    end
                end
                D_DONE: begin
                    frame_pulse <= 1'b0;
                    busy        <= 1'b0;
                    div_state   <= D_IDLE;
                end
                default: div_state <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_centroid_extract.sv
// Bench for line_centroid_extract.
//
// Expected results come from a frame-level model. The driver knows the
// row/column of every pixel it sends. For each frame it totals the yellow
// ROI pixels and their x coordinates, then predicts the published record:
// the frame end cycle + 33, width, floor(sum/count) and detected. Records
// queue in exp_q. A compare process checks every output on every cycle
// against the held model values and the queue head.

module tb_line_centroid_extract;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'd0;
    logic        frame_pulse;
    logic [15:0] width;
    logic [15:0] centroid_x;
    logic        detected;
    logic        busy;
    logic        overrun;

    line_centroid_extract dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_pulse (frame_pulse),
        .width       (width),
        .centroid_x  (centroid_x),
        .detected    (detected),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    typedef struct packed {
        logic [31:0] due;
        logic [15:0] w;
        logic [31:0] q;
        logic        det;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   rec_in;
    exp_t   rec_out;

    int     n_checks = 0;
    int     n_fail = 0;
    bit     run_chk = 1'b0;
    int     pulse_cnt = 0;

    // Frame model
    bit     m_active = 1'b0;
    int     m_cnt = 0;
    longint m_sum = 0;
    int     m_lastw = 0;
    int     m_y = 0;
    int     bs = 1;
    int     be = 0;
    int     ovr_from = 32'h7fffffff;
    int     h_width = 0;
    int     h_cx = 0;
    int     h_det = 0;
    bit     iir_seen = 1'b0;
    bit     ep;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_yellow(input logic [15:0] p);
        return (p[15:11] >= 5'd20) && (p[10:5] >= 6'd40) && (p[4:0] <= 5'd12);
    endfunction

    function automatic logic [15:0] rand_pix();
        case ($urandom_range(0, 7))
            0: return 16'hFFE0;
            1: return 16'hF7E0;
            2: return 16'hA50C;   // R=20 G=40 B=12: exactly on every threshold
            3: return 16'h9D0C;   // R=19
            4: return 16'hA4EC;   // G=39
            5: return 16'hA50D;   // B=13
            6: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Compare process
    always @(negedge clk) begin
        if (run_chk && !reset) begin
            ep = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                rec_out = exp_q.pop_front();
                ep      = 1'b1;
                h_width = int'(rec_out.w);
                h_det   = int'(rec_out.det);
`ifdef LINE_CENTROID_IIR_EN
                if (rec_out.det) begin
                    if (!iir_seen) h_cx = int'(rec_out.q[15:0]);
                    else           h_cx = (3 * h_cx + int'(rec_out.q[15:0])) / 4;
                    iir_seen = 1'b1;
                end
`else
                h_cx = rec_out.det ? int'(rec_out.q[15:0]) : 0;
`endif
            end
            if (frame_pulse) pulse_cnt++;
            check("frame_pulse", 32'(frame_pulse), 32'(ep));
            check("width", 32'(width), h_width);
            check("centroid_x", 32'(centroid_x), h_cx);
            check("detected", 32'(detected), h_det);
            check("busy", 32'(busy), 32'(cyc >= bs && cyc <= be));
            check("overrun", 32'(overrun), 32'(cyc >= ovr_from));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vsync = 1'b0;
        href = 1'b0;
        pix_valid = 1'b0;
        pix_data = 16'd0;
        exp_q.delete();
        m_active = 1'b0;
        m_cnt = 0;
        m_sum = 0;
        m_lastw = 0;
        m_y = 0;
        bs = 1;
        be = 0;
        ovr_from = 32'h7fffffff;
        h_width = 0;
        h_cx = 0;
        h_det = 0;
        iir_seen = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // A frame boundary: vsync high for two cycles, then low.
    task automatic vs_pulse();
        href = 1'b0;
        pix_valid = 1'b0;
        vsync = 1'b1;
        if (!m_active) begin
            m_active = 1'b1;
        end else if (cyc >= bs && cyc <= be) begin
            if (ovr_from > cyc + 1) ovr_from = cyc + 1;
        end else begin
            rec_in.due = 32'(cyc + 33);
            rec_in.w   = 16'(m_lastw);
            rec_in.q   = (m_cnt == 0) ? 32'd0 : 32'(m_sum / m_cnt);
            rec_in.det = (m_cnt >= 64);
            exp_q.push_back(rec_in);
            bs = cyc + 1;
            be = cyc + 33;
        end
        m_cnt = 0;
        m_sum = 0;
        m_lastw = 0;
        m_y = 0;
        tick();
        tick();
        vsync = 1'b0;
        tick();
    endtask

    // One line of len pixels. Mode 0 puts col on x in [a,b] and black
    // elsewhere. Mode 1 picks random palette colours. With gaps, idle
    // href cycles are mixed in.
    task automatic send_row(input int len, input int mode, input int a, input int b,
                            input logic [15:0] col, input bit gaps);
        int x;
        logic [15:0] p;
        x = 0;
        if (len == 0) begin
            href = 1'b1;
            pix_valid = 1'b0;
            tick();
        end
        while (x < len) begin
            href = 1'b1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                pix_data = 16'($urandom);
            end else begin
                p = (mode == 1) ? rand_pix() : ((x >= a && x <= b) ? col : 16'h0000);
                pix_valid = 1'b1;
                pix_data = p;
                if (is_yellow(p) && m_y >= 240 && m_y <= 479) begin
                    m_cnt++;
                    m_sum += x;
                end
                x++;
            end
            tick();
        end
        href = 1'b0;
        pix_valid = 1'b0;
        pix_data = 16'd0;
        tick();
        tick();
        m_lastw = len;
        m_y++;
    endtask

    task automatic empty_rows(input int n);
        for (int i = 0; i < n; i++) send_row(0, 0, 1, 0, 16'h0000, 1'b0);
    endtask

    // Stimulus
    initial begin
        run_chk = 1'b1;
        tick();
        do_reset();
        check("reset_width", 32'(width), 0);
        check("reset_centroid", 32'(centroid_x), 0);
        check("reset_detected", 32'(detected), 0);
        check("reset_overrun", 32'(overrun), 0);

        // Yellow band x=300..339 on ROI rows; the first edge only opens a frame.
        vs_pulse();
        empty_rows(240);
        for (int r = 0; r < 4; r++) send_row(640, 0, 300, 339, 16'hFFE0, 1'b0);
        vs_pulse();
        idle(40);
        check("band_width", 32'(width), 640);
        check("band_detected", 32'(detected), 1);
        check("band_centroid", 32'(centroid_x), 319);

        // Same band, but only on rows above the ROI.
        for (int r = 0; r < 4; r++) send_row(640, 0, 300, 339, 16'hFFE0, 1'b0);
        vs_pulse();
        idle(40);
        check("noroi_width", 32'(width), 640);
        check("noroi_detected", 32'(detected), 0);
`ifndef LINE_CENTROID_IIR_EN
        check("noroi_centroid", 32'(centroid_x), 0);
`endif

        // MIN_COUNT threshold: 63, then 64 yellow pixels at x=100.
        empty_rows(240);
        for (int r = 0; r < 63; r++) send_row(101, 0, 100, 100, 16'hFFE0, 1'b0);
        vs_pulse();
        idle(40);
        check("min63_detected", 32'(detected), 0);
        check("min63_width", 32'(width), 101);
        empty_rows(240);
        for (int r = 0; r < 64; r++) send_row(101, 0, 100, 100, 16'hFFE0, 1'b0);
        vs_pulse();
        idle(40);
        check("min64_detected", 32'(detected), 1);
`ifndef LINE_CENTROID_IIR_EN
        check("min64_centroid", 32'(centroid_x), 100);
`endif

        // Colour classification: white fails on B; 0xF7E0 is yellow.
        empty_rows(240);
        for (int r = 0; r < 2; r++) send_row(640, 0, 0, 65535, 16'hFFFF, 1'b0);
        vs_pulse();
        idle(40);
        check("white_detected", 32'(detected), 0);
        empty_rows(240);
        for (int r = 0; r < 2; r++) send_row(640, 0, 0, 65535, 16'hF7E0, 1'b0);
        vs_pulse();
        idle(40);
        check("f7e0_detected", 32'(detected), 1);
`ifndef LINE_CENTROID_IIR_EN
        check("f7e0_centroid", 32'(centroid_x), 319);
`endif

        // Last ROI row included, the row after it excluded.
        empty_rows(479);
        send_row(64, 0, 0, 63, 16'hFFE0, 1'b0);
        send_row(164, 0, 100, 163, 16'hFFE0, 1'b0);
        vs_pulse();
        idle(40);
        check("roi_end_width", 32'(width), 164);
        check("roi_end_detected", 32'(detected), 1);
`ifndef LINE_CENTROID_IIR_EN
        check("roi_end_centroid", 32'(centroid_x), 31);
`endif

        // Reset in the middle of a frame; the next edge only starts a frame.
        empty_rows(300);
        do_reset();
        vs_pulse();
        idle(40);
        check("rst_width", 32'(width), 0);
        check("rst_centroid", 32'(centroid_x), 0);
        check("rst_detected", 32'(detected), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);

        // Centroid 100 frame, then a second edge 10 cycles later.
        empty_rows(240);
        for (int r = 0; r < 2; r++) send_row(133, 0, 68, 132, 16'hFFE0, 1'b0);
        pulse_cnt = 0;
        vs_pulse();
        idle(7);
        vs_pulse();
        idle(40);
        check("ovr_overrun", 32'(overrun), 1);
        check("ovr_pulses", 32'(pulse_cnt), 1);
        check("ovr_width", 32'(width), 133);
        check("ovr_centroid", 32'(centroid_x), 100);

        // Centroid 200 frame (smoothed to 125 when filtering is on).
        empty_rows(240);
        send_row(233, 0, 168, 232, 16'hFFE0, 1'b0);
        vs_pulse();
        idle(40);
        check("c200_detected", 32'(detected), 1);
`ifdef LINE_CENTROID_IIR_EN
        check("c200_centroid", 32'(centroid_x), 125);
`else
        check("c200_centroid", 32'(centroid_x), 200);
`endif

        // Random frames, some short enough to collide with the divider.
        for (int f = 0; f < 8; f++) begin
            int nrows;
            if ($urandom_range(0, 3) == 0) empty_rows(0);
            else empty_rows($urandom_range(235, 245));
            nrows = $urandom_range(0, 5);
            for (int r = 0; r < nrows; r++) send_row($urandom_range(0, 150), 1, 0, 0, 16'h0000, 1'b1);
            vs_pulse();
            idle($urandom_range(0, 45));
        end
        idle(45);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
